// File: rtl/io_output_reg_pkg.sv
// Shared I/O package: address-select codes for the memory-mapped I/O
// window, status word bit positions, mailbox state encoding and a helper
// that packs the status word. Both the output-side register block and the
// input-side read mux import it, so the decode values live in one place.
package io_output_reg_pkg;

  // Word selects decoded from addr[7:2]
  localparam logic [5:0] SEL_PORT0  = 6'b100000;
  localparam logic [5:0] SEL_PORT1  = 6'b100001;
  localparam logic [5:0] SEL_MBOX   = 6'b100010;
  localparam logic [5:0] SEL_STATUS = 6'b100011;

  // Status word layout
  localparam int STAT_VALID_BIT = 0;
  localparam int STAT_OVF_BIT   = 1;
  localparam int STAT_CNT_LSB   = 8;

  typedef enum logic {
    MBOX_EMPTY = 1'b0,
    MBOX_FULL  = 1'b1
  } mbox_state_t;

  // Packs valid, overflow and the write counter; all other bits read as 0.
  function automatic logic [31:0] status_word(input logic valid,
                                              input logic overflow,
                                              input logic [7:0] count);
    logic [31:0] w;
    w = '0;
    w[STAT_VALID_BIT] = valid;
    w[STAT_OVF_BIT]   = overflow;
    w[STAT_CNT_LSB +: 8] = count;
    return w;
  endfunction

endpackage

// File: rtl/io_output_reg_mailbox.sv
// io_mailbox: single-entry mailbox towards an external device.
// Holds the EMPTY/FULL state, the data word, a sticky overflow flag and an
// 8-bit count of accepted stores.
//   io_clk, resetn : clock, async active-low reset
//   store          : decoded store to the mailbox address this cycle
//   store_data     : data carried by that store
//   ack            : external device consumed the current word
//   clear_ovf      : decoded request to clear the overflow flag
//   data, valid    : mailbox contents and occupancy
//   overflow, count: sticky drop flag and accepted-store counter
module io_mailbox
  import io_output_reg_pkg::*;
(
  input  logic        io_clk,
  input  logic        resetn,
  input  logic        store,
  input  logic [31:0] store_data,
  input  logic        ack,
  input  logic        clear_ovf,
  output logic [31:0] data,
  output logic        valid,
  output logic        overflow,
  output logic [7:0]  count
);

  mbox_state_t state_q, state_d;
  logic [31:0] data_d;
  logic        ovf_d;
  logic [7:0]  count_d;

  always_ff @(posedge io_clk or negedge resetn) begin
    if (!resetn) begin
      state_q  <= MBOX_EMPTY;
      data     <= '0;
      overflow <= 1'b0;
      count    <= '0;
    end else begin
      state_q  <= state_d;
      data     <= data_d;
      overflow <= ovf_d;
      count    <= count_d;
    end
  end

  // A store when FULL is accepted only if the ack in the same cycle frees
  // the slot; otherwise it is dropped and recorded as overflow. An ack while
  // EMPTY has nothing to consume and is ignored.
  always_comb begin
    state_d = state_q;
    data_d  = data;
    ovf_d   = overflow;
    count_d = count;
    unique case (state_q)
      MBOX_EMPTY: begin
        if (store) begin
          data_d  = store_data;
          state_d = MBOX_FULL;
          count_d = count + 8'd1;
        end
      end
      MBOX_FULL: begin
        if (store && ack) begin
          data_d  = store_data;
          count_d = count + 8'd1;
        end else if (store) begin
          ovf_d = 1'b1;
        end else if (ack) begin
          state_d = MBOX_EMPTY;
        end
      end
      default: state_d = MBOX_EMPTY;
    endcase
    // Clear and set target different addresses so they never coincide.
    if (clear_ovf) ovf_d = 1'b0;
  end

  assign valid = (state_q == MBOX_FULL);

endmodule

// File: rtl/io_output_reg.sv
// io_output_reg: CPU-side output registers of the I/O window.
//   io_clk, resetn   : clock, async active-low reset
//   addr, datain     : CPU store address (addr[7:2] decoded) and data
//   write_io_enable  : one-cycle store strobe into the I/O space
//   out_port0/1      : plain output registers, reset to OUT_RESET
//   out_port2(_valid): mailbox data and occupancy
//   out_port2_ack    : device consumed the mailbox word
//   io_status_data   : registered status word (one cycle behind)
module io_output_reg
  import io_output_reg_pkg::*;
#(
  parameter logic [31:0] OUT_RESET = 32'h0000_0000
) (
  input  logic        io_clk,
  input  logic        resetn,
  input  logic [31:0] addr,
  input  logic [31:0] datain,
  input  logic        write_io_enable,
  output logic [31:0] out_port0,
  output logic [31:0] out_port1,
  output logic [31:0] out_port2,
  output logic        out_port2_valid,
  input  logic        out_port2_ack,
  output logic [31:0] io_status_data
);

  logic [5:0] sel;
  logic       unused_addr;
  logic       mbox_overflow;
  logic [7:0] mbox_count;

  assign sel         = addr[7:2];
  assign unused_addr = ^{addr[31:8], addr[1:0]};

  io_mailbox u_mailbox (
    .io_clk     (io_clk),
    .resetn     (resetn),
    .store      (write_io_enable && (sel == SEL_MBOX)),
    .store_data (datain),
    .ack        (out_port2_ack),
    .clear_ovf  (write_io_enable && (sel == SEL_STATUS) && datain[STAT_OVF_BIT]),
    .data       (out_port2),
    .valid      (out_port2_valid),
    .overflow   (mbox_overflow),
    .count      (mbox_count)
  );

  // Plain port registers; stores to other selects leave them untouched.
  always_ff @(posedge io_clk or negedge resetn) begin
    if (!resetn) begin
      out_port0 <= OUT_RESET;
      out_port1 <= OUT_RESET;
    end else if (write_io_enable) begin
      if (sel == SEL_PORT0) out_port0 <= datain;
      if (sel == SEL_PORT1) out_port1 <= datain;
    end
  end

  // Status snapshot of the mailbox state as it stood before this edge,
  // captured every cycle so the readback never depends on addr.
  always_ff @(posedge io_clk or negedge resetn) begin
    if (!resetn) io_status_data <= '0;
    else         io_status_data <= status_word(out_port2_valid, mbox_overflow, mbox_count);
  end

endmodule
